motor_drive_controller: RTL and testbench

Downstream consumer of the collision detector's drive/stop flag: converts a commanded speed and direction into H-bridge control (PWM enable plus two direction inputs) for one drive motor. Applies a linear soft-start ramp, short-circuit braking on collision stop or direction reversal, and glitch-free duty updates aligned to PWM period boundaries. Sits between the collision detector and the motor driver pins.

---
 rtl/motor_drive_controller_pkg.sv | 17 +
 rtl/motor_drive_controller_if.sv | 24 ++
 rtl/motor_drive_controller_pwm.sv | 45 ++++
 rtl/motor_drive_controller.sv | 134 +++++++++++++
 tb/tb_motor_drive_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_drive_controller_pkg.sv
// Shared types and constants for the motor drive path; the DRIVE/STOP
// encoding matches the collision detector's output flag.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    RUN   = 2'd2,
    BRAKE = 2'd3
  } state_t;

  localparam logic FORWARDS  = 1'b1;
  localparam logic BACKWARDS = 1'b0;
  localparam logic DRIVE     = 1'b1;
  localparam logic STOP      = 1'b0;

endpackage

// File: rtl/motor_drive_controller_if.sv
// Command/bridge bundle between the supervisor side and the motor drive controller.
interface motor_drive_controller_if;

  logic       direction;
  logic       col_detect;
  logic [7:0] speed_cmd;
  logic       pwm;
  logic       in1;
  logic       in2;
  logic       moving;
  logic [1:0] state_out;
  logic       period_start;

  modport master (
    output direction, col_detect, speed_cmd,
    input  pwm, in1, in2, moving, state_out, period_start
  );

  modport slave (
    input  direction, col_detect, speed_cmd,
    output pwm, in1, in2, moving, state_out, period_start
  );

endinterface

// File: rtl/motor_drive_controller_pwm.sv
// Prescaled 8-bit PWM: the duty is latched only at the period wrap so a
// running period never changes shape mid-way.
module pwm_generator #(
  parameter int PWM_PRESCALE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] duty_tgt,
  output logic       pwm_raw,
  output logic       period_start
);

  localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PWM_PRESCALE - 1);

  logic [PW-1:0] presc;
  logic [7:0]    pwm_cnt;
  logic [7:0]    duty_act;
  logic          step;

  assign step = (presc == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc        <= '0;
      pwm_cnt      <= '0;
      duty_act     <= '0;
      period_start <= 1'b0;
    end else begin
      presc        <= step ? '0 : presc + PW'(1);
      period_start <= 1'b0;
      if (step) begin
        pwm_cnt <= pwm_cnt + 8'd1;
        if (pwm_cnt == 8'hFF) begin
          duty_act     <= duty_tgt;
          period_start <= 1'b1;
        end
      end
    end
  end

  // Strict compare: duty 0 never fires, duty 255 leaves one low step per period.
  assign pwm_raw = (pwm_cnt < duty_act);

endmodule

// File: rtl/motor_drive_controller.sv
// H-bridge drive controller: soft-start ramp, short-circuit brake on stop or
// reversal, and coast when idle. All bridge outputs are registered.
module motor_drive_controller
  import motor_pkg::*;
#(
  parameter int PWM_PRESCALE     = 8,
  parameter int RAMP_STEP_CYCLES = 50_000,
  parameter int BRAKE_CYCLES     = 500_000
) (
  input  logic                     clk,
  input  logic                     rst,
  motor_drive_controller_if.slave  bus
);

  localparam int RW = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
  localparam int BW = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;
  localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_STEP_CYCLES - 1);
  localparam logic [BW-1:0] BRAKE_LAST = BW'(BRAKE_CYCLES - 1);

  state_t        state;
  logic [7:0]    duty_tgt;
  logic          dir_q;
  logic [RW-1:0] ramp_cnt;
  logic [BW-1:0] brake_cnt;
  logic          pwm_q, in1_q, in2_q, moving_q;
  logic          pwm_raw, period_start;
  logic          abort;

  pwm_generator #(.PWM_PRESCALE(PWM_PRESCALE)) u_pwm (
    .clk          (clk),
    .rst          (rst),
    .duty_tgt     (duty_tgt),
    .pwm_raw      (pwm_raw),
    .period_start (period_start)
  );

  // A stop and a reversal share one brake interval.
  assign abort = (bus.col_detect == STOP) || (bus.direction != dir_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      duty_tgt  <= '0;
      dir_q     <= FORWARDS;
      ramp_cnt  <= '0;
      brake_cnt <= '0;
      pwm_q     <= 1'b0;
      in1_q     <= 1'b0;
      in2_q     <= 1'b0;
      moving_q  <= 1'b0;
    end else begin
      pwm_q    <= 1'b0;
      in1_q    <= 1'b0;
      in2_q    <= 1'b0;
      moving_q <= 1'b0;
      case (state)
        IDLE: begin
          duty_tgt  <= '0;
          ramp_cnt  <= '0;
          brake_cnt <= '0;
          if (bus.col_detect == DRIVE && bus.speed_cmd != 8'd0) begin
            dir_q    <= bus.direction;
            state    <= RAMP;
            moving_q <= 1'b1;
            in1_q    <= bus.direction;
            in2_q    <= ~bus.direction;
          end
        end
        RAMP, RUN: begin
          if (abort) begin
            state     <= BRAKE;
            brake_cnt <= '0;
            ramp_cnt  <= '0;
            duty_tgt  <= '0;
            pwm_q     <= 1'b1;
            in1_q     <= 1'b1;
            in2_q     <= 1'b1;
          end else if (bus.speed_cmd == 8'd0) begin
            state    <= IDLE;
            ramp_cnt <= '0;
            duty_tgt <= '0;
          end else begin
            moving_q <= 1'b1;
            in1_q    <= dir_q;
            in2_q    <= ~dir_q;
            pwm_q    <= pwm_raw;
            if (state == RUN) begin
              if (bus.speed_cmd < duty_tgt) begin
                duty_tgt <= bus.speed_cmd;
              end else if (bus.speed_cmd > duty_tgt) begin
                state    <= RAMP;
                ramp_cnt <= '0;
              end
            end else if (bus.speed_cmd <= duty_tgt) begin
              duty_tgt <= bus.speed_cmd;
              state    <= RUN;
              ramp_cnt <= '0;
            end else if (ramp_cnt == RAMP_LAST) begin
              ramp_cnt <= '0;
              duty_tgt <= duty_tgt + 8'd1;
              if (duty_tgt + 8'd1 == bus.speed_cmd) state <= RUN;
            end else begin
              ramp_cnt <= ramp_cnt + RW'(1);
            end
          end
        end
        BRAKE: begin
          pwm_q <= 1'b1;
          in1_q <= 1'b1;
          in2_q <= 1'b1;
          if (brake_cnt == BRAKE_LAST) begin
            state     <= IDLE;
            brake_cnt <= '0;
            ramp_cnt  <= '0;
            pwm_q     <= 1'b0;
            in1_q     <= 1'b0;
            in2_q     <= 1'b0;
          end else begin
            brake_cnt <= brake_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pwm          = pwm_q;
  assign bus.in1          = in1_q;
  assign bus.in2          = in2_q;
  assign bus.moving       = moving_q;
  assign bus.state_out    = state;
  assign bus.period_start = period_start;

endmodule

// File: tb/tb_motor_drive_controller.sv
// Scenario bench for motor_drive_controller with small timing parameters.
module tb_motor_drive_controller;

  localparam int PRE   = 1;
  localparam int RSTEP = 4;
  localparam int BRK   = 10;
  localparam int LIMIT = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  motor_drive_controller_if bus();

  motor_drive_controller #(
    .PWM_PRESCALE(PRE), .RAMP_STEP_CYCLES(RSTEP), .BRAKE_CYCLES(BRK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: expectations straight from the drive rules.
  function automatic int ref_ramp_cycles(input int from_d, input int to_d);
    return (to_d - from_d) * RSTEP;
  endfunction

  function automatic int ref_period_high(input int duty);
    return (duty * 256) / 256;
  endfunction

  function automatic logic [1:0] ref_bridge_dir(input logic dir);
    return dir ? 2'b10 : 2'b01;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic count_state(input logic [1:0] st, output int n, output int hi3);
    n = 0;
    hi3 = 0;
    while (bus.state_out == st && n < LIMIT) begin
      if (bus.pwm && bus.in1 && bus.in2) hi3++;
      n++;
      tick();
    end
  endtask

  task automatic count_high(input int len, output int h);
    h = 0;
    repeat (len) begin
      h += int'(bus.pwm);
      tick();
    end
  endtask

  task automatic wait_period(output bit ok);
    int k;
    k = 0;
    while (bus.period_start !== 1'b1 && k < 600) begin
      tick();
      k++;
    end
    ok = (bus.period_start === 1'b1);
  endtask

  task automatic start_drive(input logic dir, input logic [7:0] spd);
    bus.direction  = dir;
    bus.col_detect = 1'b1;
    bus.speed_cmd  = spd;
    tick();
  endtask

  task automatic go_idle;
    int k;
    bus.col_detect = 1'b0;
    bus.speed_cmd  = 8'd0;
    k = 0;
    tick();
    while (bus.state_out != 2'd0 && k < 40) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset;
    int n, hi;
    bus.direction = 1'b0; bus.col_detect = 1'b0; bus.speed_cmd = 8'd0;
    #2 rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.pwm, bus.in1, bus.in2, bus.moving} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000", {bus.pwm, bus.in1, bus.in2, bus.moving});
    end
    checks++;
    if (bus.state_out !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_out);
    end
    rst = 1'b1;
    start_drive(1'b1, 8'd8);
    repeat (10) tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.pwm, bus.in1, bus.in2, bus.moving, bus.state_out} !== 6'b0) begin
      errors++; $display("FAIL async_reset_midramp: got %b expected 000000", {bus.pwm, bus.in1, bus.in2, bus.moving, bus.state_out});
    end
    checks++;
    if (dut.duty_tgt !== 8'd0) begin
      errors++; $display("FAIL async_reset_duty: got %0d expected 0", dut.duty_tgt);
    end
    tick();
    rst = 1'b1;
    tick();
    count_state(2'd1, n, hi);
    checks++;
    if (n != ref_ramp_cycles(0, 8)) begin
      errors++; $display("FAIL ramp_after_reset: got %0d cycles expected %0d", n, ref_ramp_cycles(0, 8));
    end
  endtask

  task automatic test_soft_start;
    int n, hi, h;
    go_idle();
    checks++;
    if (bus.state_out !== 2'd0) begin
      errors++; $display("FAIL soft_idle: got %0d expected 0", bus.state_out);
    end
    start_drive(1'b1, 8'd8);
    checks++;
    if ({bus.state_out, bus.in1, bus.in2, bus.moving} !== {2'd1, ref_bridge_dir(1'b1), 1'b1}) begin
      errors++; $display("FAIL soft_entry: got %b expected %b", {bus.state_out, bus.in1, bus.in2, bus.moving}, {2'd1, ref_bridge_dir(1'b1), 1'b1});
    end
    count_state(2'd1, n, hi);
    checks++;
    if (n != ref_ramp_cycles(0, 8)) begin
      errors++; $display("FAIL soft_ramp_len: got %0d expected %0d", n, ref_ramp_cycles(0, 8));
    end
    checks++;
    if (bus.state_out !== 2'd2) begin
      errors++; $display("FAIL soft_run: got %0d expected 2", bus.state_out);
    end
    repeat (300) tick();
    count_high(256, h);
    checks++;
    if (h != ref_period_high(8)) begin
      errors++; $display("FAIL soft_duty: got %0d high expected %0d", h, ref_period_high(8));
    end
  endtask

  task automatic test_collision;
    int n, hi;
    bus.col_detect = 1'b0;
    tick();
    checks++;
    if ({bus.state_out, bus.pwm, bus.in1, bus.in2, bus.moving} !== {2'd3, 4'b1110}) begin
      errors++; $display("FAIL col_brake_latency: got %b expected 1111 10", {bus.state_out, bus.pwm, bus.in1, bus.in2, bus.moving});
    end
    bus.col_detect = 1'b1;
    count_state(2'd3, n, hi);
    checks++;
    if (n != BRK || hi != BRK) begin
      errors++; $display("FAIL col_brake_len: got %0d cycles %0d active expected %0d", n, hi, BRK);
    end
    checks++;
    if ({bus.state_out, bus.pwm, bus.in1, bus.in2} !== 5'b0) begin
      errors++; $display("FAIL col_coast: got %b expected 00000", {bus.state_out, bus.pwm, bus.in1, bus.in2});
    end
    tick();
    checks++;
    if (bus.state_out !== 2'd1) begin
      errors++; $display("FAIL col_restart: got %0d expected 1", bus.state_out);
    end
  endtask

  task automatic test_reversal;
    int n, hi, h;
    go_idle();
    start_drive(1'b1, 8'd20);
    count_state(2'd1, n, hi);
    bus.direction = 1'b0;
    tick();
    checks++;
    if (bus.state_out !== 2'd3) begin
      errors++; $display("FAIL rev_brake: got %0d expected 3", bus.state_out);
    end
    count_state(2'd3, n, hi);
    checks++;
    if (n != BRK || bus.state_out !== 2'd0) begin
      errors++; $display("FAIL rev_brake_len: got %0d cycles state %0d expected %0d then 0", n, bus.state_out, BRK);
    end
    tick();
    checks++;
    if ({bus.state_out, bus.in1, bus.in2} !== {2'd1, ref_bridge_dir(1'b0)}) begin
      errors++; $display("FAIL rev_ramp_dir: got %b expected %b", {bus.state_out, bus.in1, bus.in2}, {2'd1, ref_bridge_dir(1'b0)});
    end
    count_state(2'd1, n, hi);
    checks++;
    if (n != ref_ramp_cycles(0, 20)) begin
      errors++; $display("FAIL rev_ramp_len: got %0d expected %0d", n, ref_ramp_cycles(0, 20));
    end
    repeat (300) tick();
    count_high(256, h);
    checks++;
    if (h != ref_period_high(20)) begin
      errors++; $display("FAIL rev_duty: got %0d expected %0d", h, ref_period_high(20));
    end
  endtask

  task automatic test_duty_decrease;
    int n, hi, h1, h2;
    bit ok;
    bus.speed_cmd = 8'd40;
    tick();
    count_state(2'd1, n, hi);
    checks++;
    if (n != ref_ramp_cycles(20, 40)) begin
      errors++; $display("FAIL dec_reramp_len: got %0d expected %0d", n, ref_ramp_cycles(20, 40));
    end
    repeat (300) tick();
    wait_period(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL dec_period_wait: got timeout expected period_start");
    end
    tick();
    h1 = 0;
    for (int i = 0; i < 256; i++) begin
      h1 += int'(bus.pwm);
      if (i == 20) bus.speed_cmd = 8'd10;
      tick();
      if (i == 20) begin
        checks++;
        if (dut.duty_tgt !== 8'd10 || bus.state_out !== 2'd2) begin
          errors++; $display("FAIL dec_tgt_next: got duty %0d state %0d expected 10 and 2", dut.duty_tgt, bus.state_out);
        end
      end
    end
    count_high(256, h2);
    checks++;
    if (h1 != ref_period_high(40)) begin
      errors++; $display("FAIL dec_current_period: got %0d expected %0d", h1, ref_period_high(40));
    end
    checks++;
    if (h2 != ref_period_high(10)) begin
      errors++; $display("FAIL dec_next_period: got %0d expected %0d", h2, ref_period_high(10));
    end
  endtask

  task automatic test_zero_full;
    int n, hi, h;
    bus.speed_cmd = 8'd0;
    tick();
    checks++;
    if ({bus.state_out, bus.pwm, bus.in1, bus.in2, bus.moving} !== 6'b0) begin
      errors++; $display("FAIL zero_coast: got %b expected 000000", {bus.state_out, bus.pwm, bus.in1, bus.in2, bus.moving});
    end
    start_drive(1'b1, 8'd255);
    count_state(2'd1, n, hi);
    checks++;
    if (n != ref_ramp_cycles(0, 255)) begin
      errors++; $display("FAIL full_ramp_len: got %0d expected %0d", n, ref_ramp_cycles(0, 255));
    end
    repeat (300) tick();
    count_high(256, h);
    checks++;
    if (256 - h != 1) begin
      errors++; $display("FAIL full_low_cycles: got %0d expected 1", 256 - h);
    end
  endtask

  task automatic test_simultaneous;
    int n, hi;
    bus.col_detect = 1'b0;
    bus.direction  = 1'b0;
    tick();
    count_state(2'd3, n, hi);
    checks++;
    if (n != BRK) begin
      errors++; $display("FAIL simul_brake_len: got %0d expected %0d", n, BRK);
    end
    repeat (5) tick();
    checks++;
    if ({bus.state_out, bus.in1, bus.in2, bus.pwm} !== 5'b0) begin
      errors++; $display("FAIL simul_stays_idle: got %b expected 00000", {bus.state_out, bus.in1, bus.in2, bus.pwm});
    end
  endtask

  task automatic test_random;
    int n, hi, h, spd, ex;
    logic dir;
    for (int it = 0; it < 4; it++) begin
      spd = int'($urandom_range(60, 1));
      dir = 1'($urandom_range(1, 0));
      ex  = int'($urandom_range(2, 0));
      go_idle();
      start_drive(dir, 8'(spd));
      checks++;
      if ({bus.in1, bus.in2} !== ref_bridge_dir(dir)) begin
        errors++; $display("FAIL rnd_dir it%0d: got %b expected %b", it, {bus.in1, bus.in2}, ref_bridge_dir(dir));
      end
      count_state(2'd1, n, hi);
      checks++;
      if (n != ref_ramp_cycles(0, spd)) begin
        errors++; $display("FAIL rnd_ramp it%0d: got %0d expected %0d", it, n, ref_ramp_cycles(0, spd));
      end
      repeat (300) tick();
      count_high(256, h);
      checks++;
      if (h != ref_period_high(spd)) begin
        errors++; $display("FAIL rnd_duty it%0d: got %0d expected %0d", it, h, ref_period_high(spd));
      end
      if (ex == 0) bus.col_detect = 1'b0;
      else if (ex == 1) bus.direction = ~dir;
      else bus.speed_cmd = 8'd0;
      tick();
      if (ex == 2) begin
        checks++;
        if ({bus.state_out, bus.pwm, bus.in1, bus.in2} !== 5'b0) begin
          errors++; $display("FAIL rnd_zero it%0d: got %b expected 00000", it, {bus.state_out, bus.pwm, bus.in1, bus.in2});
        end
      end else begin
        count_state(2'd3, n, hi);
        checks++;
        if (n != BRK || hi != BRK) begin
          errors++; $display("FAIL rnd_brake it%0d: got %0d/%0d expected %0d", it, n, hi, BRK);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_soft_start();
    test_collision();
    test_reversal();
    test_duty_decrease();
    test_zero_full();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
